ksa_pg_sum_pipe: RTL
====================

// Module: ksa_pg_sum_pipe
// PURPOSE
//   Operand-side partner of the 32-bit carry chain. Accepts operand pairs A/B
//   over a valid/ready handshake and forms P = A^B and G = A&B. It then
//   resolves carries with a Kogge-Stone prefix (log2(WIDTH) levels) and returns
//   SUM = P ^ C[WIDTH-1:0], together with carry-out and signed overflow.
//   The block is a 2-stage pipeline that sits between the ALU operand mux and
//   the writeback register.
// PARAMETERS
//   WIDTH  32  operand width; must be a power of 2, >= 4
// PORTS
//   clk_i        in   1      clock, rising edge
//   rst_i        in   1      asynchronous, active-high reset
//   in_valid_i   in   1      operand beat valid
//   in_ready_o   out  1      block can accept an operand beat this cycle
//   A_i          in   WIDTH  operand A
//   B_i          in   WIDTH  operand B
//   C_i          in   1      carry-in
//   out_valid_o  out  1      result beat valid
//   out_ready_i  in   1      downstream accepts the result beat
//   S_o          out  WIDTH  sum
//   C_o          out  1      carry-out (bit WIDTH of the carry vector)
//   V_o          out  1      signed overflow = C[WIDTH] ^ C[WIDTH-1]
// BEHAVIOUR
//   - Reset (async assert, sync deassert by the system): s1_valid=0, s2_valid=0,
//     out_valid_o=0, S_o=0, C_o=0, V_o=0, and all stage data registers cleared.
//   - Stage 1 (S1): on an accepted input (in_valid_i & in_ready_o), register
//     P=A_i^B_i, G=A_i&B_i and cin=C_i, and set s1_valid=1.
//   - Stage 2 (S2): the carry vector C[0]=cin. C[i+1] = G[i] | P[i]&C[i],
//     evaluated as a Kogge-Stone prefix over (G,P) with cin folded in at
//     bit 0. Register S_o=P^C[WIDTH-1:0], C_o=C[WIDTH] and
//     V_o=C[WIDTH]^C[WIDTH-1], then set s2_valid=1.
//   - Latency: 2 clk_i cycles from input accept to out_valid_o, when
//     unstalled.
//   - Throughput: 1 beat per cycle when out_ready_i is held at 1.
//   - Flow control:
//     - s2_adv = s1_valid & (!s2_valid | out_ready_i).
//     - in_ready_o = !s1_valid | s2_adv. It is combinational, with no
//       bubble when the pipe is full and draining.
//   - Handshake rules:
//     - While out_valid_o=1 & out_ready_i=0, S_o/C_o/V_o hold stable.
//     - out_valid_o never deasserts without a handshake.
//   - Simultaneous events:
//     - Output pop plus S1 advance in the same cycle: S2 reloads with no
//       gap.
//     - Input accept plus S1 advance in the same cycle: S1 reloads with no
//       gap.
//     - Beats are never dropped or duplicated, and order is preserved.
//   - A_i/B_i/C_i are sampled only on accept and ignored otherwise (may be X).
//   - Arithmetic is modulo 2^WIDTH. C_o is the unsigned carry and V_o is
//     two's-complement overflow.
//   - Reset mid-operation: all in-flight beats are discarded, and the first
//     post-reset output comes only from a post-reset accept.
//   - Full pipe (2 beats held) with out_ready_i=0: in_ready_o=0.
// TESTING
//   1. Basic: A=0x0000_0005, B=0x0000_0003, C_i=0 -> after 2 cycles S=0x0000_0008,
//      C_o=0, V_o=0.
//   2. Full ripple: A=0xFFFF_FFFF, B=0x0000_0000, C_i=1 -> S=0x0000_0000, C_o=1, V_o=0.
//   3. Overflow: A=0x7FFF_FFFF, B=0x0000_0001, C_i=0 -> S=0x8000_0000, C_o=0, V_o=1;
//      A=B=0x8000_0000 -> S=0, C_o=1, V_o=1.
//   4. Backpressure: stream 4 beats with out_ready_i=0 -> in_ready_o drops after
//      2 accepts; S_o stable; on release, 4 results in order, 1/cycle.
//   5. Reset mid-flight: accept 2 beats, assert rst_i asynchronously -> out_valid_o=0
//      immediately, no stale beat emerges after release.
//   6. Random: 10k random A/B/C_i with random out_ready_i -> every S/C_o/V_o
//      matches {C_o,S}=A+B+C_i scoreboard, count in == count out.

Source files
------------

// File: rtl/ksa_pg_sum_pipe.sv
// Two-stage adder pipeline: stage 1 registers propagate/generate, stage 2 resolves
// carries with a Kogge-Stone prefix and registers sum, carry-out and overflow.
module ksa_pg_sum_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic             C_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] S_o,
    output logic             C_o,
    output logic             V_o
);

    localparam int LEVELS = $clog2(WIDTH);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_p;
    logic [WIDTH-1:0] s1_g;
    logic             s1_cin;
    logic             s2_valid;
    logic             s2_adv;
    logic             in_fire;

    assign s2_adv      = s1_valid & (~s2_valid | out_ready_i);
    assign in_ready_o  = ~s1_valid | s2_adv;
    assign in_fire     = in_valid_i & in_ready_o;
    assign out_valid_o = s2_valid;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_p     <= '0;
            s1_g     <= '0;
            s1_cin   <= 1'b0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_p     <= A_i ^ B_i;
            s1_g     <= A_i & B_i;
            s1_cin   <= C_i;
        end else if (s2_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Carry-in is folded into bit 0's generate so the prefix yields C[i+1] directly.
    logic [WIDTH-1:0] gk [LEVELS+1];
    logic [WIDTH-1:0] pk [LEVELS];

    assign gk[0] = {s1_g[WIDTH-1:1], s1_g[0] | (s1_p[0] & s1_cin)};
    assign pk[0] = s1_p;

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int D = 1 << l;
        assign gk[l+1] = gk[l] | (pk[l] & (gk[l] << D));
        if (l < LEVELS - 1) begin : g_p
            // Bits below the span distance keep their group propagate unchanged.
            localparam logic [WIDTH-1:0] LOW = {WIDTH{1'b1}} >> (WIDTH - D);
            assign pk[l+1] = pk[l] & ((pk[l] << D) | LOW);
        end
    end

    logic [WIDTH:0] carry;
    assign carry = {gk[LEVELS], s1_cin};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s2_valid <= 1'b0;
            S_o      <= '0;
            C_o      <= 1'b0;
            V_o      <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= 1'b1;
            S_o      <= s1_p ^ carry[WIDTH-1:0];
            C_o      <= carry[WIDTH];
            V_o      <= carry[WIDTH] ^ carry[WIDTH-1];
        end else if (out_ready_i) begin
            s2_valid <= 1'b0;
        end
    end

endmodule
